// File: rtl/cpu_sequencer.sv
// cpu_sequencer: variable-length CPU control sequencer.
// Walks each instruction through fetch/execute micro-steps and presents one state code per step.
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   opcode     - instruction opcode, sampled only on the edge leaving FETCH_INST
//   mem_ready  - memory step complete (FETCH_INST, RAM_A, RAM_B, STORE_A stall while low)
//   zero_flag  - ALU zero flag, resolves JEZ/JNZ on the edge leaving the operand FETCH_PC
//   resume     - leave HALT
//   state      - current micro-step code
//   cycle      - step index within the current instruction
//   instr_done - high while state is NEXT
//   halted     - high while state is HALT
//   illegal_op - sticky illegal-opcode flag, cleared only by reset
module cpu_sequencer #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned STATE_W  = 4,
  parameter int unsigned CYCLE_W  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero_flag,
  input  logic                resume,
  output logic [STATE_W-1:0]  state,
  output logic [CYCLE_W-1:0]  cycle,
  output logic                instr_done,
  output logic                halted,
  output logic                illegal_op
);

  localparam logic [STATE_W-1:0] StIdle     = STATE_W'(4'h0);
  localparam logic [STATE_W-1:0] StFetchPc  = STATE_W'(4'h1);
  localparam logic [STATE_W-1:0] StFetchIns = STATE_W'(4'h2);
  localparam logic [STATE_W-1:0] StHalt     = STATE_W'(4'h3);
  localparam logic [STATE_W-1:0] StJump     = STATE_W'(4'h4);
  localparam logic [STATE_W-1:0] StOutA     = STATE_W'(4'h5);
  localparam logic [STATE_W-1:0] StAluOp    = STATE_W'(4'h6);
  localparam logic [STATE_W-1:0] StRamA     = STATE_W'(4'h7);
  localparam logic [STATE_W-1:0] StRamB     = STATE_W'(4'h8);
  localparam logic [STATE_W-1:0] StStoreA   = STATE_W'(4'h9);
  localparam logic [STATE_W-1:0] StLoadAddr = STATE_W'(4'hA);
  localparam logic [STATE_W-1:0] StNext     = STATE_W'(4'hB);

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpOut = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJez = 4'h7;
  localparam logic [3:0] OpJnz = 4'h8;
  localparam logic [3:0] OpHlt = 4'hF;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [3:0]         op_q, op_d;
  logic               illegal_q, illegal_d;
  logic               done_q, done_d;
  logic               halted_q, halted_d;
  logic               hold;
  logic               restart;
  logic               op_illegal;

  // Only the low nibble is ever decoded; anything wider or in 9..E is illegal.
  always_comb begin
    op_illegal = ((opcode >> 4) != '0) || ((opcode[3:0] >= 4'h9) && (opcode[3:0] <= 4'hE));
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    hold      = 1'b0;
    restart   = 1'b0;

    case (state_q)
      StIdle: begin
        state_d = StFetchPc;
        restart = 1'b1;
      end
      StFetchPc: begin
        // Step 0 fetches the instruction; a later FETCH_PC fetches its operand.
        if (cycle_q == '0) begin
          state_d = StFetchIns;
        end else begin
          case (op_q)
            OpLda, OpSta, OpAdd, OpSub: state_d = StLoadAddr;
            OpJmp:                      state_d = StJump;
            OpJez:                      state_d = zero_flag ? StJump : StNext;
            OpJnz:                      state_d = zero_flag ? StNext : StJump;
            default:                    state_d = StNext;
          endcase
        end
      end
      StFetchIns: begin
        if (!mem_ready) begin
          hold = 1'b1;
        end else begin
          op_d = opcode[3:0];
          if (op_illegal) begin
            illegal_d = 1'b1;
            state_d   = StNext;
          end else begin
            case (opcode[3:0])
              OpNop:   state_d = StNext;
              OpHlt:   state_d = StHalt;
              OpOut:   state_d = StOutA;
              default: state_d = StFetchPc;
            endcase
          end
        end
      end
      StLoadAddr: begin
        case (op_q)
          OpLda:   state_d = StRamA;
          OpSta:   state_d = StStoreA;
          default: state_d = StRamB;
        endcase
      end
      StRamB: begin
        if (!mem_ready) hold = 1'b1;
        else            state_d = StAluOp;
      end
      StRamA, StStoreA: begin
        if (!mem_ready) hold = 1'b1;
        else            state_d = StNext;
      end
      StHalt: begin
        if (!resume) hold = 1'b1;
        else         state_d = StNext;
      end
      StJump, StOutA, StAluOp: state_d = StNext;
      StNext: begin
        state_d = StFetchPc;
        restart = 1'b1;
      end
      default: begin
        state_d = StIdle;
        restart = 1'b1;
      end
    endcase

    if (hold)         cycle_d = cycle_q;
    else if (restart) cycle_d = '0;
    else              cycle_d = cycle_q + CYCLE_W'(1);

    // Flags are registered from the next state so they line up with state.
    done_d   = (state_d == StNext);
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cycle_q   <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      halted_q  <= halted_d;
    end
  end

  assign state      = state_q;
  assign cycle      = cycle_q;
  assign instr_done = done_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: bench for cpu_sequencer (OPCODE_W=6 so wide illegal opcodes are reachable).
// Table of directed vectors, hand sequences for async reset and wide opcodes, then random
// stimulus; every cycle is also compared to a per-instruction step-list model.
module tb_cpu_sequencer;
  localparam int unsigned OW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [OW-1:0] opcode = '0;
  logic          mem_ready = 1'b0;
  logic          zero_flag = 1'b0;
  logic          resume = 1'b0;
  logic [3:0]    state;
  logic [3:0]    cycle;
  logic          instr_done, halted, illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_sequencer #(
    .OPCODE_W(OW),
    .STATE_W (4),
    .CYCLE_W (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .zero_flag (zero_flag),
    .resume    (resume),
    .state     (state),
    .cycle     (cycle),
    .instr_done(instr_done),
    .halted    (halted),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction is a list of state codes, index = cycle.
  logic [3:0]    m_seq[$];
  int            m_idx;
  bit            m_idle;
  bit            m_ill;
  logic [OW-1:0] m_op;

  function automatic bit is_illegal(input logic [OW-1:0] op);
    return (op > 6'd15) || ((op >= 6'd9) && (op <= 6'd14));
  endfunction

  function automatic void push_nibbles(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) m_seq.push_back(w[4*i +: 4]);
  endfunction

  function automatic void model_reset();
    m_idle = 1'b1;
    m_ill  = 1'b0;
    m_idx  = 0;
    m_seq.delete();
  endfunction

  function automatic void model_start();
    m_idle = 1'b0;
    m_seq.delete();
    push_nibbles(32'h12, 2);
    m_idx = 0;
  endfunction

  function automatic void model_step(input logic [OW-1:0] op, input bit mr, input bit zf,
                                     input bit rs);
    logic [3:0] cur;
    if (m_idle) begin
      model_start();
      return;
    end
    cur = m_seq[m_idx];
    if ((cur == 4'h2 || cur == 4'h7 || cur == 4'h8 || cur == 4'h9) && !mr) return;
    if (cur == 4'h3 && !rs) return;
    if (cur == 4'hB) begin
      model_start();
      return;
    end
    if (m_idx == 1) begin
      m_op = op;
      if (is_illegal(op)) begin
        m_ill = 1'b1;
        push_nibbles(32'hB, 1);
      end else begin
        case (op)
          6'd0:          push_nibbles(32'hB, 1);
          6'd1:          push_nibbles(32'h1A7B, 4);
          6'd2, 6'd3:    push_nibbles(32'h1A86B, 5);
          6'd4:          push_nibbles(32'h1A9B, 4);
          6'd5:          push_nibbles(32'h5B, 2);
          6'd6, 6'd7, 6'd8: push_nibbles(32'h14B, 3);
          default:       push_nibbles(32'h3B, 2);
        endcase
      end
    end
    // Conditional jump not taken: drop the JUMP step.
    if (m_idx == 2 && ((m_op == 6'd7 && !zf) || (m_op == 6'd8 && zf))) m_seq.delete(3);
    m_idx++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0] es;
    es = m_idle ? 4'h0 : m_seq[m_idx];
    chk("state", 32'(state), 32'(es));
    chk("cycle", 32'(cycle), m_idle ? 32'd0 : 32'(m_idx));
    chk("instr_done", 32'(instr_done), 32'(es == 4'hB));
    chk("halted", 32'(halted), 32'(es == 4'h3));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
  endtask

  task automatic tick(input logic [OW-1:0] op, input bit mr, input bit zf, input bit rs);
    opcode    = op;
    mem_ready = mr;
    zero_flag = zf;
    resume    = rs;
    @(posedge clk);
    model_step(op, mr, zf, rs);
    #1;
    check_model();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [OW-1:0] op;
    bit            mr;
    bit            zf;
    bit            rs;
    logic [3:0]    st;
    int            cy;
    bit            ill;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [OW-1:0] op, input bit mr, input bit zf, input bit rs,
                              input logic [3:0] st, input int cy, input bit ill);
    vec_t v;
    v.op = op; v.mr = mr; v.zf = zf; v.rs = rs; v.st = st; v.cy = cy; v.ill = ill;
    vecs.push_back(v);
  endfunction

  // n rows with mem_ready=1, resume=0; expected states are the nibbles of w, cycles from c0.
  function automatic void run(input logic [OW-1:0] op, input bit zf, input logic [31:0] w,
                              input int n, input int c0, input bit ill);
    for (int i = 0; i < n; i++) add(op, 1'b1, zf, 1'b0, w[4*(n-1-i) +: 4], c0 + i, ill);
  endfunction

  initial begin
    logic [OW-1:0] rop;

    // ADD, LDA with RAM_A stall, LDA with FETCH_INST stall (opcode changes while stalled).
    run(6'd2, 1'b0, 32'h121A86B, 7, 0, 1'b0);
    run(6'd1, 1'b0, 32'h121A7, 5, 0, 1'b0);
    for (int i = 0; i < 3; i++) add(6'd1, 1'b0, 1'b0, 1'b0, 4'h7, 4, 1'b0);
    add(6'd1, 1'b1, 1'b0, 1'b0, 4'hB, 5, 1'b0);
    add(6'd5, 1'b0, 1'b0, 1'b0, 4'h1, 0, 1'b0);
    for (int i = 0; i < 3; i++) add(6'd5, 1'b0, 1'b0, 1'b0, 4'h2, 1, 1'b0);
    run(6'd1, 1'b0, 32'h1A7B, 4, 2, 1'b0);
    // JEZ / JNZ both ways.
    run(6'd7, 1'b1, 32'h1214B, 5, 0, 1'b0);
    run(6'd7, 1'b0, 32'h121B, 4, 0, 1'b0);
    run(6'd8, 1'b0, 32'h1214B, 5, 0, 1'b0);
    run(6'd8, 1'b1, 32'h121B, 4, 0, 1'b0);
    // HLT held 10 cycles with mem_ready toggling, then resume.
    run(6'd15, 1'b0, 32'h123, 3, 0, 1'b0);
    for (int i = 0; i < 10; i++) add(6'd15, 1'(i % 2), 1'b0, 1'b0, 4'h3, 2, 1'b0);
    add(6'd15, 1'b1, 1'b0, 1'b1, 4'hB, 3, 1'b0);
    // Illegal 0xC, then legal OUT and NOP keep the sticky flag.
    add(6'd12, 1'b1, 1'b0, 1'b0, 4'h1, 0, 1'b0);
    add(6'd12, 1'b1, 1'b0, 1'b0, 4'h2, 1, 1'b0);
    add(6'd12, 1'b1, 1'b0, 1'b0, 4'hB, 2, 1'b1);
    run(6'd5, 1'b0, 32'h125B, 4, 0, 1'b1);
    run(6'd0, 1'b0, 32'h12B, 3, 0, 1'b1);
    add(6'd2, 1'b1, 1'b0, 1'b0, 4'h1, 0, 1'b1);

    #2;
    do_reset();
    foreach (vecs[i]) begin
      tick(vecs[i].op, vecs[i].mr, vecs[i].zf, vecs[i].rs);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("tbl%0d_cycle", i), 32'(cycle), 32'(vecs[i].cy));
      chk($sformatf("tbl%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
    end

    // Asynchronous reset in ALU_OP of an ADD, illegal flag still set from the table.
    repeat (5) tick(6'd2, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_state", 32'(state), 32'h6);
    chk("pre_reset_illegal", 32'(illegal_op), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'h0);
    chk("async_cycle", 32'(cycle), 32'h0);
    chk("async_illegal", 32'(illegal_op), 32'h0);
    chk("async_done", 32'(instr_done), 32'h0);
    do_reset();
    chk("post_rel_state", 32'(state), 32'h0);
    tick(6'd0, 1'b1, 1'b0, 1'b0);
    chk("post_rel_fetch", 32'(state), 32'h1);
    chk("post_rel_cycle", 32'(cycle), 32'h0);
    chk("post_rel_illegal", 32'(illegal_op), 32'h0);

    // Wide opcode 0x12: low nibble is ADD but upper bits make it illegal.
    tick(6'h12, 1'b1, 1'b0, 1'b0);
    tick(6'h12, 1'b1, 1'b0, 1'b0);
    chk("wide_state", 32'(state), 32'hB);
    chk("wide_cycle", 32'(cycle), 32'h2);
    chk("wide_illegal", 32'(illegal_op), 32'h1);

    // Random stimulus against the model, with an occasional reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 0) rop = OW'($urandom_range(0, 8));
      else if ($urandom_range(0, 1) == 0) rop = 6'd15;
      else rop = OW'($urandom_range(0, 63));
      if ($urandom_range(0, 999) == 0) do_reset();
      tick(rop, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
